keypad_scanner: RTL and testbench
=================================

// Module: keypad_scanner
// PURPOSE
//  Scans a 4x4 matrix keypad on the board and reports debounced key presses to the core.
//  Drives one active-low column at a time and samples the active-low rows, so it is the input-side counterpart of the 7-seg digit scan.
//  Emits a 4-bit key code, a one-cycle press strobe and a held level.
//  Sits in top beside the display path; its outputs feed CPU stepping or select logic.
// PARAMETERS
//  SCAN_DIV        100000  CLK cycles per column slot; must be >= 4 (about 1 ms at 100 MHz)
//  DEBOUNCE_SCANS  4       consecutive identical full scans required to accept a press or a release; must be >= 1
// PORTS
//  CLK        in   1  system clock; all state on posedge CLK
//  Reset      in   1  asynchronous, active-low reset
//  row_in     in   4  keypad rows, active-low, pulled up externally, asynchronous to CLK
//  col_out    out  4  column drive, active-low, exactly one bit low at all times
//  key_code   out  4  {row_idx[1:0], col_idx[1:0]} of the accepted key
//  key_valid  out  1  one-cycle pulse when a press is accepted
//  key_down   out  1  high from press acceptance until release is accepted
// BEHAVIOUR
//  Reset (async, Reset=0):
//   - col_out=4'b1110, key_code=0, key_valid=0, key_down=0, FSM=IDLE
//   - all counters and candidate registers cleared
//  Synchronisation and column scan:
//   - row_in passes through a 2-FF synchroniser.
//   - slot counter runs 0..SCAN_DIV-1. At the terminal count, the synchronised rows are sampled for the current column, then col_out rotates left (1110->1101->1011->0111->1110).
//   - the sample at the end of each slot gives SCAN_DIV-1 cycles of settling.
//  Scan result:
//   - after the col 3 sample, one full scan (4 slots) is classified as NONE, SINGLE(k) or MULTI.
//   - SINGLE means exactly one low row bit across all 4 columns; k = row*4+col.
//   - "scan end" is the single cycle in which this result is valid.
//  FSM (evaluated only at scan end; otherwise holds):
//   - IDLE: SINGLE(k) -> DEBOUNCE, cand=k, cnt=1. NONE or MULTI -> stay.
//   - DEBOUNCE: SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE_SCANS -> PRESSED, key_code=cand, key_valid=1 for exactly one cycle, key_down=1. Any other result -> IDLE.
//   - PRESSED: NONE -> RELEASE, cnt=1. Anything else -> stay (no auto-repeat; key_code is held).
//   - RELEASE: NONE -> cnt++. When cnt reaches DEBOUNCE_SCANS -> IDLE, key_down=0. Any non-NONE -> PRESSED, cnt cleared.
//   - DEBOUNCE_SCANS=1: accept on the first matching scan, i.e. IDLE->PRESSED and PRESSED->IDLE directly.
//  Outputs:
//   - key_code changes only on acceptance; it keeps its last value after release.
//  Latency:
//   - press: 2 sync cycles + up to 1 scan of alignment + DEBOUNCE_SCANS scans + 1 cycle to key_valid.
//   - release: similar to press, to key_down fall.
//  Boundaries:
//   - slot and column counters wrap silently.
//   - a new press is only possible after a release has been accepted.
//   - reset mid-operation returns to the reset values immediately and the scan restarts at col 0.
// STRUCTURE
//  keypad_pkg:
//   - ROWS=4, COLS=4
//   - FSM state enum {IDLE,DEBOUNCE,PRESSED,RELEASE}
//   - scan-result enum {NONE,SINGLE,MULTI}
//  Sub-module row_sync2: 2-FF synchroniser for row_in (4 bits, async active-low reset to 4'hF).
//  The slot counter, column ring, scan accumulator and FSM stay in this module.
// TESTING (SCAN_DIV=4, DEBOUNCE_SCANS=3, 1 scan=16 cycles; the keypad model pulls row r low when its column is driven low and key (r,c) is held)
//  1. Release Reset -> col_out=1110, outputs 0; col_out=1101 after 4 cycles, back to 1110 after 16.
//  2. Hold key (2,1) -> exactly one key_valid pulse with key_code=4'h9 and key_down=1, within 2+16+48+1 cycles.
//  3. Hold key (0,3) for 1 scan only -> no key_valid; key_code stays 0; FSM returns to IDLE.
//  4. Hold key (3,3) for 20 scans, then release -> one pulse with code 4'hF; key_down falls 3 to 4 scans after release.
//  5. From IDLE, hold keys (1,0) and (1,2) together -> MULTI every scan; no key_valid and key_down stays 0.
//  6. Press (2,2), pull Reset low mid-DEBOUNCE -> all outputs 0 and col_out=1110 asynchronously; after release of Reset, the press is re-accepted.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
package keypad_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 4;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
    typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_res_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [1:0] first_set(input logic [3:0] v);
        first_set = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (v[i]) first_set = 2'(i);
    endfunction
endpackage

// File: rtl/keypad_scanner_row_sync2.sv
// Two-flop synchroniser for the asynchronous, active-low keypad rows.
module row_sync2
    import keypad_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] d,
    output logic [ROWS-1:0] q
);
    logic [ROWS-1:0] meta;

    // Reset to all-high so no key appears pressed while coming out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column ring drive, per-scan classification and
// a debounce FSM producing key_code, a press strobe and a held level.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic [ROWS-1:0] row_in,
    output logic [COLS-1:0] col_out,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_down
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_SCANS);

    logic [ROWS-1:0] row_s, row_low;
    logic [SW-1:0]   slot_cnt;
    logic [1:0]      col_idx;
    logic [1:0]      acc_cnt;
    logic [3:0]      acc_key;
    logic [2:0]      n_now, tot;
    logic            slot_end, scan_end;
    scan_res_t       res;
    logic [3:0]      res_key;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, cnt_inc;
    logic [3:0]      cand, cand_n, code_n;
    logic            valid_n, down_n;

    row_sync2 u_sync (.clk(CLK), .rst_n(Reset), .d(row_in), .q(row_s));

    assign row_low  = ~row_s;
    assign n_now    = popcount4(row_low);
    assign tot      = {1'b0, acc_cnt} + n_now;
    assign slot_end = (slot_cnt == SLOT_LAST);
    assign scan_end = slot_end && (col_idx == 2'd3);
    assign col_out  = ~(4'b0001 << col_idx);
    assign cnt_inc  = cnt + CW'(1);

    // The last column's sample is folded in combinationally so the result is valid at scan end.
    always_comb begin
        res_key = (acc_cnt != 2'd0) ? acc_key : {first_set(row_low), col_idx};
        if (tot == 3'd0)      res = NONE;
        else if (tot == 3'd1) res = SINGLE;
        else                  res = MULTI;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            acc_cnt  <= 2'd0;
            acc_key  <= 4'd0;
        end else begin
            slot_cnt <= slot_end ? '0 : slot_cnt + SW'(1);
            if (slot_end) begin
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    acc_cnt <= 2'd0;
                    acc_key <= 4'd0;
                end else begin
                    // Saturate at 2: anything beyond "more than one" is just MULTI.
                    acc_cnt <= (tot > 3'd2) ? 2'd2 : tot[1:0];
                    if (acc_cnt == 2'd0 && n_now == 3'd1)
                        acc_key <= {first_set(row_low), col_idx};
                end
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        cand_n  = cand;
        code_n  = key_code;
        valid_n = 1'b0;
        down_n  = key_down;
        if (scan_end) begin
            case (state)
                IDLE: if (res == SINGLE) begin
                    cand_n = res_key;
                    if (DEBOUNCE_SCANS == 1) begin
                        state_n = PRESSED;
                        code_n  = res_key;
                        valid_n = 1'b1;
                        down_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        state_n = DEBOUNCE;
                        cnt_n   = CW'(1);
                    end
                end
                DEBOUNCE: if (res == SINGLE && res_key == cand) begin
                    if (cnt_inc == CNT_DONE) begin
                        state_n = PRESSED;
                        code_n  = cand;
                        valid_n = 1'b1;
                        down_n  = 1'b1;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
                PRESSED: if (res == NONE) begin
                    if (DEBOUNCE_SCANS == 1) begin
                        state_n = IDLE;
                        down_n  = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        state_n = RELEASE;
                        cnt_n   = CW'(1);
                    end
                end
                RELEASE: if (res == NONE) begin
                    if (cnt_inc == CNT_DONE) begin
                        state_n = IDLE;
                        down_n  = 1'b0;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end else begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cand      <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cand      <= cand_n;
            key_code  <= code_n;
            key_valid <= valid_n;
            key_down  <= down_n;
        end
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model drives the rows, stimulus is held
// per full scan and outputs are compared against a scan-level behavioural model.
module tb_keypad_scanner;
    localparam int SD = 4;
    localparam int DS = 3;
    localparam int SCAN = 4 * SD;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic [3:0] row_in, col_out, key_code;
    logic       key_valid, key_down;
    logic [15:0] held = 16'h0;

    int errors = 0;
    int checks = 0;

    // Scan-level reference: a run counter of consecutive qualifying scans.
    bit         m_pressed;
    int         m_run, m_cand, exp_pulse;
    logic [3:0] m_code;

    int         o_pulses;
    logic [3:0] o_code;
    logic       o_down;

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .CLK(CLK), .Reset(Reset), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
    );

    always #5 CLK = ~CLK;

    // Key (r,c) held pulls row r low while column c is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!col_out[c] && held[r*4+c]) row_in[r] = 1'b0;
    end

    task automatic mdl_reset();
        m_pressed = 0; m_run = 0; m_cand = 0; m_code = 4'h0; exp_pulse = 0;
    endtask

    task automatic mdl_step(input logic [15:0] keys);
        int n, k;
        n = $countones(keys);
        k = 0;
        for (int i = 0; i < 16; i++) if (keys[i]) k = i;
        exp_pulse = 0;
        if (!m_pressed) begin
            if (n == 1 && m_run > 0 && k == m_cand) m_run++;
            else if (n == 1 && m_run == 0) begin m_cand = k; m_run = 1; end
            else m_run = 0;
            if (m_run == DS) begin
                m_pressed = 1; m_code = 4'(m_cand); exp_pulse = 1; m_run = 0;
            end
        end else begin
            if (n == 0) m_run++; else m_run = 0;
            if (m_run == DS) begin m_pressed = 0; m_run = 0; end
        end
    endtask

    // Holds a key set for one full scan and records what the DUT showed.
    task automatic run_scan(input logic [15:0] keys);
        held = keys;
        o_pulses = 0;
        repeat (SCAN) begin
            @(posedge CLK); #1;
            if (key_valid) o_pulses++;
        end
        o_code = key_code;
        o_down = key_down;
        mdl_step(keys);
    endtask

    task automatic test_reset();
        logic [3:0] e;
        mdl_reset();
        held = 16'h0;
        #2 Reset = 1'b0;
        #10;
        checks++;
        if ({col_out, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_state: got col=%b code=%h v=%b d=%b want col=1110 code=0 v=0 d=0",
                     col_out, key_code, key_valid, key_down);
        end
        @(negedge CLK) Reset = 1'b1;
        for (int i = 1; i <= SCAN; i++) begin
            @(posedge CLK); #1;
            e = 4'b0001 << ((i / SD) % 4);
            e = ~e;
            checks++;
            if (col_out !== e) begin
                errors++;
                $display("FAIL col_rotate cycle %0d: got %b want %b", i, col_out, e);
            end
        end
        mdl_step(16'h0);
    endtask

    task automatic test_short_press();
        for (int s = 0; s < 4; s++) begin
            run_scan(s == 0 ? 16'h0008 : 16'h0000);
            checks++;
            if (o_pulses !== exp_pulse || o_code !== m_code || o_down !== m_pressed) begin
                errors++;
                $display("FAIL short_press scan %0d: got p=%0d code=%h d=%b want p=%0d code=%h d=%b",
                         s, o_pulses, o_code, o_down, exp_pulse, m_code, m_pressed);
            end
        end
        checks++;
        if (o_code !== 4'h0) begin
            errors++;
            $display("FAIL short_press_code: got %h want 0", o_code);
        end
    endtask

    task automatic test_press();
        int total = 0;
        for (int s = 0; s < 8; s++) begin
            run_scan(s < 4 ? 16'h0200 : 16'h0000);
            total += o_pulses;
            checks++;
            if (o_pulses !== exp_pulse || o_code !== m_code || o_down !== m_pressed) begin
                errors++;
                $display("FAIL press_21 scan %0d: got p=%0d code=%h d=%b want p=%0d code=%h d=%b",
                         s, o_pulses, o_code, o_down, exp_pulse, m_code, m_pressed);
            end
            if (s == 2) begin
                checks++;
                if ({o_pulses, o_code, o_down} !== {32'd1, 4'h9, 1'b1}) begin
                    errors++;
                    $display("FAIL press_21_latency: got p=%0d code=%h d=%b want p=1 code=9 d=1",
                             o_pulses, o_code, o_down);
                end
            end
        end
        checks++;
        if (total !== 1) begin
            errors++;
            $display("FAIL press_21_pulses: got %0d want 1", total);
        end
    endtask

    task automatic test_hold_release();
        int total = 0;
        int fall = -1;
        for (int s = 0; s < 26; s++) begin
            run_scan(s < 20 ? 16'h8000 : 16'h0000);
            total += o_pulses;
            if (s >= 20 && fall < 0 && !o_down) fall = s - 19;
            checks++;
            if (o_pulses !== exp_pulse || o_code !== m_code || o_down !== m_pressed) begin
                errors++;
                $display("FAIL hold_33 scan %0d: got p=%0d code=%h d=%b want p=%0d code=%h d=%b",
                         s, o_pulses, o_code, o_down, exp_pulse, m_code, m_pressed);
            end
        end
        checks++;
        if (total !== 1 || o_code !== 4'hF || fall < 3 || fall > 4) begin
            errors++;
            $display("FAIL hold_33_release: got pulses=%0d code=%h fall_scans=%0d want 1 F 3..4",
                     total, o_code, fall);
        end
    endtask

    task automatic test_multi();
        for (int s = 0; s < 7; s++) begin
            run_scan(s < 6 ? 16'h0050 : 16'h0000);
            checks++;
            if (o_pulses !== 0 || o_down !== 1'b0 || o_pulses !== exp_pulse || o_down !== m_pressed) begin
                errors++;
                $display("FAIL multi scan %0d: got p=%0d d=%b want p=0 d=0", s, o_pulses, o_down);
            end
        end
    endtask

    task automatic test_reset_mid();
        run_scan(16'h0400);
        repeat (7) @(posedge CLK);
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({col_out, key_code, key_valid, key_down} !== {4'b1110, 4'h0, 2'b00}) begin
            errors++;
            $display("FAIL reset_mid: got col=%b code=%h v=%b d=%b want col=1110 code=0 v=0 d=0",
                     col_out, key_code, key_valid, key_down);
        end
        mdl_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK) Reset = 1'b1;
        for (int s = 0; s < 6; s++) begin
            run_scan(s < 3 ? 16'h0400 : 16'h0000);
            checks++;
            if (o_pulses !== exp_pulse || o_code !== m_code || o_down !== m_pressed) begin
                errors++;
                $display("FAIL reset_mid_repress scan %0d: got p=%0d code=%h d=%b want p=%0d code=%h d=%b",
                         s, o_pulses, o_code, o_down, exp_pulse, m_code, m_pressed);
            end
        end
        checks++;
        if (o_code !== 4'hA) begin
            errors++;
            $display("FAIL reset_mid_code: got %h want a", o_code);
        end
    endtask

    task automatic test_random();
        logic [15:0] keys;
        int b1, b2, hold, s;
        s = 0;
        while (s < 80) begin
            case ($urandom_range(0, 3))
                0: keys = 16'h0;
                3: begin
                    b1 = $urandom_range(0, 15);
                    b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
                    keys = (16'h1 << b1) | (16'h1 << b2);
                end
                default: keys = 16'h1 << $urandom_range(0, 15);
            endcase
            hold = $urandom_range(1, 5);
            for (int h = 0; h < hold; h++) begin
                run_scan(keys);
                checks++;
                if (o_pulses !== exp_pulse || o_code !== m_code || o_down !== m_pressed) begin
                    errors++;
                    $display("FAIL random scan %0d keys=%h: got p=%0d code=%h d=%b want p=%0d code=%h d=%b",
                             s, keys, o_pulses, o_code, o_down, exp_pulse, m_code, m_pressed);
                end
                s++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_press();
        test_hold_release();
        test_multi();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
